// File: rtl/adc_pkg.sv
// Shared types and frame constants for the MCP3008-class ADC access arbiter.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int FRAME_CLKS     = 17;
  localparam int NULL_IDX       = 6;
  localparam int FIRST_DATA_IDX = NULL_IDX + 1;
  localparam int ADC_BITS       = 10;

  // Command bit presented on DIN during SCLK period k: start, SGL/DIFF, D2..D0, then zeros.
  function automatic logic cmd_bit(input logic [4:0] k, input logic sgl, input logic [2:0] ch);
    case (k)
      5'd0:    return 1'b1;
      5'd1:    return sgl;
      5'd2:    return ch[2];
      5'd3:    return ch[1];
      5'd4:    return ch[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping around.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  int cand;

  // Walk from the farthest offset down so the nearest requester after ptr_i wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = 0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(ptr_i) + off) % N;
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/adc_access_arbiter.sv
// Round-robin sharing of one SPI ADC among N_REQ requesters; owns all ADC pin timing.
module adc_access_arbiter
  import adc_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLK_DIV      = 14,
  parameter int CS_IDLE      = 27,
  parameter bit SINGLE_ENDED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [3*N_REQ-1:0]    req_ch,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [ADC_BITS-1:0]   rsp_data,
  output logic                  busy,
  output logic                  AD_CLK,
  output logic                  CS,
  output logic                  DIN,
  input  logic                  DOUT,
  output state_e                dbg_state_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int HW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  localparam logic [PW-1:0] PH_RISE   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_DIV - 1);
  localparam logic [4:0]    K_LAST    = 5'(FRAME_CLKS - 1);
  localparam logic [4:0]    K_DATA    = 5'(FIRST_DATA_IDX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CS_IDLE - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [2:0]           ch_q, ch_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic [4:0]           k_q, k_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [ADC_BITS-1:0]  shift_q, shift_d;
  logic [ADC_BITS-1:0]  rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_q, cs_d;
  logic                 din_q, din_d;
  logic [1:0]           sync_q;

  logic [N_REQ-1:0]     arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [2:0]           ch_sel;
  logic                 dout_s;
  logic                 phase_last;
  logic                 frame_end;
  logic                 hold_done;
  logic [ADC_BITS-1:0]  shift_in;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign arb_valid  = |arb_grant;
  assign dout_s     = sync_q[1];
  assign phase_last = (ph_q == PH_LAST);
  assign frame_end  = (state_q == SHIFT) && phase_last && (k_q == K_LAST);
  assign hold_done  = (state_q == HOLD) && (hold_q == HOLD_LAST);
  assign shift_in   = {shift_q[ADC_BITS-2:0], dout_s};

  always_comb begin
    ch_sel = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IW'(i)) ch_sel = req_ch[3*i +: 3];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = SHIFT;
      SHIFT:   if (frame_end) state_d = HOLD;
      HOLD:    if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; pins are re-registered so they stay glitch-free.
  always_comb begin
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    ch_d        = ch_q;
    ph_d        = ph_q;
    k_d         = k_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = '0;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    din_d       = din_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          ptr_d   = arb_idx;
          gidx_d  = arb_idx;
          ch_d    = ch_sel;
          ph_d    = '0;
          k_d     = 5'd0;
          shift_d = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          din_d   = cmd_bit(5'd0, SINGLE_ENDED, ch_sel);
        end
      end
      SHIFT: begin
        if (phase_last) begin
          if (k_q >= K_DATA) shift_d = shift_in;
          sclk_d = 1'b0;
          if (k_q == K_LAST) begin
            cs_d       = 1'b1;
            din_d      = 1'b0;
            hold_d     = '0;
            rsp_data_d = shift_in;
            for (int i = 0; i < N_REQ; i++) begin
              rsp_valid_d[i] = (gidx_q == IW'(i));
            end
          end else begin
            ph_d  = '0;
            k_d   = k_q + 5'd1;
            din_d = cmd_bit(k_q + 5'd1, SINGLE_ENDED, ch_q);
          end
        end else begin
          ph_d = ph_q + PW'(1);
          if (ph_q == PH_RISE) sclk_d = 1'b1;
        end
      end
      HOLD: begin
        hold_d = hold_q + HW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= IW'(N_REQ - 1);
      gidx_q      <= '0;
      ch_q        <= '0;
      ph_q        <= '0;
      k_q         <= '0;
      hold_q      <= '0;
      shift_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      din_q       <= 1'b0;
      sync_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      ch_q        <= ch_d;
      ph_q        <= ph_d;
      k_q         <= k_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      din_q       <= din_d;
      sync_q      <= {sync_q[0], DOUT};
    end
  end

  // busy covers the grant cycle itself, hence the combinational arb_valid term.
  assign busy        = (state_q != IDLE) || arb_valid;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign AD_CLK      = sclk_q;
  assign CS          = cs_q;
  assign DIN         = din_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_access_arbiter.sv
// Directed/randomized bench for adc_access_arbiter with a behavioural MCP3008 model.
module tb_adc_access_arbiter;
  import adc_pkg::*;

  localparam int N     = 4;
  localparam int CD    = 14;
  localparam int CSI   = 27;
  localparam int FRAME = 34 * CD;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] req_ch = '0;
  logic           DOUT = 1'b0;
  logic [N-1:0]   rsp_valid;
  logic [9:0]     rsp_data;
  logic           busy, AD_CLK, CS, DIN;
  state_e         dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_access_arbiter #(
    .N_REQ(N), .CLK_DIV(CD), .CS_IDLE(CSI), .SINGLE_ENDED(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_ch(req_ch),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .AD_CLK(AD_CLK), .CS(CS), .DIN(DIN), .DOUT(DOUT),
    .dbg_state_o(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: per-channel conversion values, DIN captured on SCLK rises,
  // DOUT advanced after each SCLK fall (null bit at period 6, B9..B0 at 7..16).
  logic [9:0]  model_val [8];
  int          rises = 0;
  int          falls = 0;
  logic [16:0] din_log = '0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic [2:0]  adc_ch;

  always @(negedge clk) begin
    if (cs_prev && !CS) begin
      rises   = 0;
      falls   = 0;
      din_log = '0;
      DOUT    = 1'b0;
    end else if (!CS) begin
      if (!sclk_prev && AD_CLK) begin
        if (rises < 17) din_log[rises] = DIN;
        rises++;
      end
      if (sclk_prev && !AD_CLK) begin
        falls++;
        adc_ch = {din_log[2], din_log[3], din_log[4]};
        if (falls >= 7 && falls <= 16) DOUT = model_val[adc_ch][16 - falls];
        else                           DOUT = 1'b0;
      end
    end
    cs_prev   = CS;
    sclk_prev = AD_CLK;
  end

  // Scoreboard state: round-robin pointer and time of last response
  int model_ptr = N - 1;
  int last_rsp  = 0;

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int off = 1; off <= N; off++) begin
      if (m[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cs_fall(output int t, output bit ok);
    ok = 1'b0;
    t  = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (CS == 1'b0) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic do_frame(input bit keep, input int drop_at, input bit gap_chk);
    int          g;
    logic [2:0]  ch;
    logic [9:0]  exp_d;
    logic [16:0] exp_din;
    int          t_fall, t_rsp;
    bit          ok;
    g       = rr_pick(req, model_ptr);
    ch      = req_ch[3*g +: 3];
    exp_d   = model_val[ch];
    exp_din = {12'b0, ch[0], ch[1], ch[2], 1'b1, 1'b1};
    wait_cs_fall(t_fall, ok);
    check("cs_fall_seen", 32'(ok), 32'd1);
    if (gap_chk) check("cs_idle_gap", t_fall - last_rsp, CSI + 1);
    ok = 1'b0;
    for (int i = 0; i < FRAME + 50; i++) begin
      @(negedge clk);
      if (drop_at > 0 && (cyc - t_fall) == drop_at) req[g] = 1'b0;
      if (rsp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
    t_rsp = cyc;
    check("rsp_seen", 32'(ok), 32'd1);
    check("rsp_latency", t_rsp - t_fall, FRAME);
    check("rsp_valid_onehot", 32'(rsp_valid), 32'(1 << g));
    check("rsp_data", 32'(rsp_data), 32'(exp_d));
    check("cs_high_at_rsp", 32'(CS), 32'd1);
    check("sclk_low_at_rsp", 32'(AD_CLK), 32'd0);
    check("busy_in_hold", 32'(busy), 32'd1);
    check("state_hold", 32'(dbg_state), 32'(HOLD));
    check("sclk_rises", rises, 17);
    check("din_bits", 32'(din_log), 32'(exp_din));
    model_ptr = g;
    last_rsp  = t_rsp;
    if (!keep) req[g] = 1'b0;
    @(negedge clk);
    check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
    check("rsp_data_held", 32'(rsp_data), 32'(exp_d));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int high_cnt;
    high_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (CS) high_cnt++;
    end
    check(tag, high_cnt, n);
  endtask

  initial begin
    int  t_fall;
    bit  ok;
    for (int c = 0; c < 8; c++) model_val[c] = 10'($urandom_range(0, 1023));

    // Reset state
    rst = 1'b1;
    tick(4);
    check("rst_cs", 32'(CS), 32'd1);
    check("rst_sclk", 32'(AD_CLK), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    model_ptr = N - 1;
    tick(2);

    // Single request, channel 5 returning 0x2A5
    model_val[5] = 10'h2A5;
    req_ch[2:0]  = 3'd5;
    req          = 4'b0001;
    do_frame(1'b0, 0, 1'b0);
    expect_quiet("cs_idle_after_single", 60);
    check("busy_idle", 32'(busy), 32'd0);
    check("state_idle", 32'(dbg_state), 32'(IDLE));

    // Round-robin with all requesters held high, from a fresh reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_ptr = N - 1;
    for (int i = 0; i < N; i++) req_ch[3*i +: 3] = 3'($urandom_range(0, 7));
    req = 4'b1111;
    for (int f = 0; f < 5; f++) do_frame(1'b1, 0, f > 0);
    req = '0;
    expect_quiet("cs_idle_after_rr", 40);

    // Wrap and skip: grant 3, then 0 and 2 only
    req_ch[11:9] = 3'($urandom_range(0, 7));
    req = 4'b1000;
    do_frame(1'b0, 0, 1'b0);
    req = 4'b0101;
    do_frame(1'b0, 0, 1'b0);
    do_frame(1'b0, 0, 1'b0);
    expect_quiet("cs_idle_after_wrap", 40);

    // Requester 1 drops its request mid-frame
    req_ch[5:3] = 3'($urandom_range(0, 7));
    req = 4'b0010;
    do_frame(1'b1, 99, 1'b0);
    check("drop_req_low", 32'(req), 32'd0);
    expect_quiet("no_regrant_after_drop", 80);

    // Reset in the middle of a frame, then a complete frame
    req_ch[8:6] = 3'($urandom_range(0, 7));
    req = 4'b0100;
    wait_cs_fall(t_fall, ok);
    check("midrst_cs_fall_seen", 32'(ok), 32'd1);
    while ((cyc - t_fall) < 199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs", 32'(CS), 32'd1);
    check("midrst_sclk", 32'(AD_CLK), 32'd0);
    check("midrst_din", 32'(DIN), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    model_ptr = N - 1;
    do_frame(1'b0, 0, 1'b0);

    // Boundary data values
    model_val[1] = 10'h000;
    model_val[6] = 10'h3FF;
    req_ch[2:0]  = 3'd1;
    req = 4'b0001;
    do_frame(1'b0, 0, 1'b0);
    tick(CSI + 5);
    req_ch[2:0] = 3'd6;
    req = 4'b0001;
    do_frame(1'b0, 0, 1'b0);
    tick(CSI + 5);
    check("busy_final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
